// File: rtl/lram_pkg.sv
// Shared widths and the read-return tag type for the local-RAM arbiter.
package lram_pkg;

    localparam int unsigned AW_DEF         = 10;
    localparam int unsigned DW_DEF         = 32;
    localparam int unsigned RD_LAT_DEF     = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_A    = 2'd1,
        TAG_B    = 2'd2
    } tag_t;

endpackage

// File: rtl/lram_tagpipe.sv
// Shift register carrying the owner of each issued read until its data returns.
module lram_tagpipe
    import lram_pkg::*;
#(
    parameter int unsigned DEPTH = RD_LAT_DEF + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t push_tag,
    output tag_t out_tag,
    output logic busy
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= TAG_NONE;
            end
        end else begin
            stage[0] <= push_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_tag = stage[DEPTH-1];

    // Any owned slot means a read is still on its way back
    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (stage[i] != TAG_NONE) begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lram_arb.sv
// Two-port arbiter/sequencer in front of the local RAM: picks one request per
// cycle, registers it onto the RAM pins and routes read data back to its owner.
module lram_arb
    import lram_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned RD_LAT     = RD_LAT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          sys_clk,
    input  logic          resetl,

    input  logic          a_req,
    input  logic          a_wr,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_rvalid,

    input  logic          b_req,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_rvalid,

    output logic [DW-1:0] rdata,

    output logic          ram_cs_n,
    output logic          ram_we_n,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,

    output logic          busy
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;
    logic          grant_a;
    logic          grant_b;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    tag_t          push_tag;
    tag_t          out_tag;

    // A has priority; B overtakes only once it has lost STARVE_MAX times in a row
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_req && b_req) begin
            if (starve_cnt == SW'(STARVE_MAX)) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end else begin
            grant_a = a_req;
            grant_b = b_req;
        end
    end

    assign a_ack = grant_a;
    assign b_ack = grant_b;

    always_comb begin
        sel_wr    = a_wr;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (grant_b) begin
            sel_wr    = b_wr;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
        push_tag = TAG_NONE;
        if (grant_a && !a_wr) begin
            push_tag = TAG_A;
        end else if (grant_b && !b_wr) begin
            push_tag = TAG_B;
        end
    end

    // A pending B that is not granted has necessarily lost to A
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            starve_cnt <= '0;
        end else if (!b_req || grant_b) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Address and write data hold when idle so the RAM pins stay quiet
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            ram_cs_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_a    <= '0;
            ram_din  <= '0;
        end else if (grant_a || grant_b) begin
            ram_cs_n <= 1'b0;
            ram_we_n <= ~sel_wr;
            ram_a    <= sel_addr;
            ram_din  <= sel_wdata;
        end else begin
            ram_cs_n <= 1'b1;
            ram_we_n <= 1'b1;
        end
    end

    lram_tagpipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tagpipe (
        .clk      (sys_clk),
        .rst_n    (resetl),
        .push_tag (push_tag),
        .out_tag  (out_tag),
        .busy     (busy)
    );

    assign a_rvalid = (out_tag == TAG_A);
    assign b_rvalid = (out_tag == TAG_B);
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_lram_arb.sv
// Randomised and directed bench for lram_arb with a behavioural RAM and
// a scoreboard of expected read returns.
module tb_lram_arb;

    localparam int unsigned AW         = 10;
    localparam int unsigned DW         = 32;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned STARVE_MAX = 4;

    typedef struct packed {
        logic          valid;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct {
        logic          port_b;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          sys_clk;
    logic          resetl;
    logic          a_req, a_wr, a_ack, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_req, b_wr, b_ack, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] rdata;
    logic          ram_cs_n, ram_we_n;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    op_t  a_ops [$];
    op_t  b_ops [$];
    exp_t sb    [$];
    logic a_took = 1'b0;
    logic b_took = 1'b0;

    logic [DW-1:0] ram_mem [1024];
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] rd_p1;

    lram_arb #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .sys_clk(sys_clk), .resetl(resetl),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid),
        .rdata(rdata),
        .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_a(ram_a), .ram_din(ram_din),
        .ram_dout(ram_dout),
        .busy(busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i) * 32'h9E37_79B9 + 32'h1357_9BDF;
    endfunction

    function automatic op_t wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.valid = 1'b1; o.wr = 1'b1; o.addr = a; o.wdata = d;
        return o;
    endfunction

    function automatic op_t rd_op(input logic [AW-1:0] a);
        op_t o;
        o.valid = 1'b1; o.wr = 1'b0; o.addr = a; o.wdata = DW'($urandom);
        return o;
    endfunction

    function automatic op_t idle_op();
        op_t o;
        o.valid = 1'b0; o.wr = 1'b0; o.addr = '0; o.wdata = '0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.valid = ($urandom_range(0, 3) != 0);
        o.wr    = 1'($urandom_range(0, 1));
        o.addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        o.wdata = DW'($urandom);
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // RAM: samples on the edge ending a cs-low cycle, read data RD_LAT cycles later
    initial begin : ram_model
        for (int i = 0; i < 1024; i++) ram_mem[i] = init_word(i);
        rd_p1    = '0;
        ram_dout = '0;
        forever begin
            @(posedge sys_clk);
            if (!ram_cs_n) begin
                if (!ram_we_n) ram_mem[ram_a] <= ram_din;
                else           rd_p1 <= ram_mem[ram_a];
            end
            ram_dout <= rd_p1;
        end
    end

    // Each port holds its request until acked, then moves to its next queued op
    initial begin : driver
        op_t op;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!a_req || a_took) begin
                if (a_ops.size() != 0 && resetl) begin
                    op = a_ops.pop_front();
                    a_req = op.valid; a_wr = op.wr; a_addr = op.addr; a_wdata = op.wdata;
                end else begin
                    a_req = 1'b0;
                end
            end
            if (!b_req || b_took) begin
                if (b_ops.size() != 0 && resetl) begin
                    op = b_ops.pop_front();
                    b_req = op.valid; b_wr = op.wr; b_addr = op.addr; b_wdata = op.wdata;
                end else begin
                    b_req = 1'b0;
                end
            end
        end
    end

    // Reference model and checker, evaluated mid-cycle
    initial begin : monitor
        exp_t          e;
        logic          win_a, win_b, p_valid, p_wr, s_wr;
        logic [AW-1:0] m_a, s_addr;
        logic [DW-1:0] m_din, s_wdata;
        int            m_starve;
        p_valid = 1'b0; p_wr = 1'b0; m_a = '0; m_din = '0; m_starve = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge sys_clk);
            cycle++;
            if (!resetl) begin
                chk("rst_cs_n",   64'(ram_cs_n), 64'd1);
                chk("rst_we_n",   64'(ram_we_n), 64'd1);
                chk("rst_ram_a",  64'(ram_a), 64'd0);
                chk("rst_din",    64'(ram_din), 64'd0);
                chk("rst_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
                chk("rst_busy",   64'(busy), 64'd0);
                chk("rst_ack",    64'({a_ack, b_ack}), 64'd0);
                sb.delete();
                m_starve = 0; p_valid = 1'b0; p_wr = 1'b0; m_a = '0; m_din = '0;
                a_took = 1'b0; b_took = 1'b0;
            end else begin
                // Only one requester wins outright; with both, B needs a full starvation run
                if (a_req && b_req) begin
                    win_b = (m_starve >= int'(STARVE_MAX));
                    win_a = !win_b;
                end else begin
                    win_a = a_req;
                    win_b = b_req;
                end
                chk("a_ack", 64'(a_ack), 64'(win_a));
                chk("b_ack", 64'(b_ack), 64'(win_b));
                a_took = a_ack;
                b_took = b_ack;

                chk("ram_cs_n", 64'(ram_cs_n), 64'(!p_valid));
                chk("ram_we_n", 64'(ram_we_n), 64'(!(p_valid && p_wr)));
                chk("ram_a",    64'(ram_a), 64'(m_a));
                chk("ram_din",  64'(ram_din), 64'(m_din));

                chk("busy", 64'(busy), 64'(sb.size() != 0));
                chk("rvalid_excl", 64'(a_rvalid && b_rvalid), 64'd0);
                if (a_rvalid || b_rvalid) begin
                    if (sb.size() == 0) begin
                        chk("rvalid_spurious", 64'({a_rvalid, b_rvalid}), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rvalid_port",  64'({a_rvalid, b_rvalid}), e.port_b ? 64'd1 : 64'd2);
                        chk("rvalid_cycle", 64'(cycle), 64'(e.due));
                        chk("rdata",        64'(rdata), 64'(e.data));
                    end
                end else if (sb.size() != 0 && sb[0].due <= cycle) begin
                    e = sb.pop_front();
                    chk("rvalid_missing", 64'({a_rvalid, b_rvalid}), e.port_b ? 64'd1 : 64'd2);
                end

                p_valid = win_a || win_b;
                s_wr    = win_b ? b_wr : a_wr;
                s_addr  = win_b ? b_addr : a_addr;
                s_wdata = win_b ? b_wdata : a_wdata;
                p_wr    = s_wr;
                if (p_valid) begin
                    m_a   = s_addr;
                    m_din = s_wdata;
                    if (s_wr) begin
                        ref_mem[s_addr] = s_wdata;
                    end else begin
                        e.port_b = win_b;
                        e.data   = ref_mem[s_addr];
                        e.due    = cycle + int'(RD_LAT) + 1;
                        sb.push_back(e);
                    end
                end
                if (b_req && win_a) m_starve = (m_starve < int'(STARVE_MAX)) ? m_starve + 1 : int'(STARVE_MAX);
                else                m_starve = 0;
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((a_ops.size() != 0 || b_ops.size() != 0 || a_req || b_req || sb.size() != 0) && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_%s: still busy after %0d cycles, required idle", name, n);
        end
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin : main
        int n;
        resetl = 1'b1;
        #1 resetl = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 resetl = 1'b1;

        a_ops.push_back(wr_op(10'h155, 32'hDEAD_BEEF));
        a_ops.push_back(rd_op(10'h155));
        drain("a_only");

        for (int i = 0; i < 15; i++) a_ops.push_back(rd_op(10'h010));
        for (int i = 0; i < 3; i++)  b_ops.push_back(rd_op(10'h020));
        drain("starve");

        a_ops.push_back(wr_op(10'h3FF, 32'h1111_1111));
        a_ops.push_back(rd_op(10'h3FF));
        drain("b2b");

        a_ops.push_back(rd_op(10'h001));
        b_ops.push_back(idle_op());
        b_ops.push_back(rd_op(10'h002));
        drain("interleave");

        repeat (10) @(negedge sys_clk);

        for (int i = 0; i < 200; i++) begin
            a_ops.push_back(rand_op());
            b_ops.push_back(rand_op());
        end
        drain("random");

        // Reset one cycle after a read is granted; its data must never return
        a_ops.push_back(rd_op(10'h0AA));
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!a_ack && n < 50);
        if (n >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL midflight_grant: no a_ack within %0d cycles, required a grant", n);
        end
        @(posedge sys_clk);
        #1 resetl = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 resetl = 1'b1;
        repeat (8) @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lram_arb.md
Name: lram_arb

Overview:
- Two-requester arbiter and sequencer sitting directly upstream of the 1024x32 GPU/DSP local RAM.
- Port A is the RISC core. Port B is the external bus, used by the 68k or blitter.
- Each cycle the block picks at most one request and registers it onto the RAM's active-low cs/we, address and write-data pins.
- It tracks read latency and returns read data to the port that issued the read.

Parameters:
AW, 10, RAM word-address width
DW, 32, data width
RD_LAT, 2, cycles from the RAM sampling a read (cs low, we high) to valid data on ram_dout
STARVE_MAX, 4, consecutive cycles port B may lose to A before B is forced through

Ports:
sys_clk  in  1  system clock, rising edge
resetl  in  1  asynchronous active-low reset
a_req  in  1  port A request; held until a_ack
a_wr  in  1  port A: 1=write, 0=read
a_addr  in  AW  port A word address
a_wdata  in  DW  port A write data
a_ack  out  1  combinational grant pulse, one cycle per accepted request
a_rvalid  out  1  port A read data valid (one-cycle pulse)
b_req, b_wr, b_addr, b_wdata, b_ack, b_rvalid  same as port A, for port B
rdata  out  DW  read data, shared; qualify with a_rvalid/b_rvalid
ram_cs_n  out  1  RAM chip select, active low, registered
ram_we_n  out  1  RAM write enable, active low, registered
ram_a  out  AW  RAM address, registered
ram_din  out  DW  RAM write data, registered
ram_dout  in  DW  RAM read data
busy  out  1  any read in flight

Behaviour:
- Reset (async assert, sync release):
  - ram_cs_n=1, ram_we_n=1, ram_a=0, ram_din=0.
  - Tag pipeline cleared; acks, rvalids and busy are 0; starve counter=0.
  - Reads in flight when reset asserts are dropped: no rvalid after release.
- Arbitration (combinational, cycle T):
  - If only one port requests, that port wins.
  - If both request, A wins unless starve_cnt==STARVE_MAX, in which case B wins.
  - Winner's ack=1 in cycle T. At most one ack per cycle.
- Starve counter:
  - Increments when b_req=1 and A wins.
  - Clears on b_ack or when b_req=0.
  - Saturates at STARVE_MAX.
- Issue:
  - At the edge ending T: ram_cs_n<=0, ram_we_n<=~wr, ram_a<=addr, ram_din<=wdata, taken from the winner.
  - The RAM sees the access in cycle T+1.
  - With no winner: ram_cs_n<=1, ram_we_n<=1; ram_a and ram_din hold.
- Throughput: back-to-back grants every cycle, no bubbles, including read-after-write and write-after-read.
- Read return:
  - A tag {none, A, B} is pushed at issue into an (RD_LAT+1)-deep shift register.
  - The matching rvalid pulses in cycle T+1+RD_LAT.
  - rdata=ram_dout, passed through combinationally; rdata is don't-care when neither rvalid is set.
  - Returns are strictly in issue order; A and B rvalid are never high in the same cycle.
- Writes produce no rvalid.
- busy=1 while any non-none tag is in the pipeline.
- RAW ordering: a write granted at T followed by a read of the same address at T+1 returns the new data. The RAM commits in order, so no forwarding logic is needed.
- Requests must be held stable until ack. Changing a request before ack is a protocol error; the design does not need to detect it.
- If req drops in the same cycle a grant would have occurred, there is no ack and no issue.

Decomposition:
- Package lram_pkg:
  - AW_DEF=10, DW_DEF=32, RD_LAT_DEF=2.
  - Tag enum: TAG_NONE=2'd0, TAG_A=2'd1, TAG_B=2'd2.
- Sub-module lram_tagpipe: parameterised tag shift register. Inputs push_tag; outputs out_tag and busy.
- Arbiter, starve counter and issue registers live in lram_arb.

Test Plan:
- Port A only: write 0xDEADBEEF to addr 0x155, then read 0x155. Required: a_ack on both cycles; ram_we_n=0 then 1; a_rvalid exactly 3 cycles after the read's ack with rdata=0xDEADBEEF; b_rvalid never set.
- Both ports request reads continuously (A at 0x010, B at 0x020), STARVE_MAX=4. Required: grant pattern A,A,A,A,B repeating; every B rvalid carries mem[0x020].
- Back-to-back: A writes 0x11111111 to 0x3FF at T and reads 0x3FF at T+1. Required: rdata=0x11111111 at T+4; ram_cs_n low in T+1 and T+2.
- Interleaved: A read 0x001 at T, B read 0x002 at T+1. Required: a_rvalid at T+3 and b_rvalid at T+4 with the correct data, never both high together.
- Reset mid-flight: issue an A read, then assert resetl=0 one cycle later for 2 cycles. Required: ram_cs_n=1 immediately; no a_rvalid after release; busy=0.
- Idle: no requests for 10 cycles. Required: ram_cs_n=1 and ram_we_n=1 throughout, ram_a held, no acks.
